// File: rtl/config_chain_loader.sv
// config_chain_loader
//   Drives the tile configuration shift-register chain. It takes host words
//   over a valid/ready handshake, clears the chain, and then shifts exactly
//   CHAIN_LENGTH bits into the chain, MSB first. When the last bit is in, it
//   reports done.
//
//   Optional feature macro: CONFIG_CRC_EN
//     When defined, a CRC-8 (poly 0x07, init 0x00) runs over every shifted
//     bit. One extra host word then carries the expected CRC in its low
//     8 bits. A mismatch sets error.
//
// Parameters
//   WORD_WIDTH    host word width (>=2)
//   CHAIN_LENGTH  total config bits in the chain
//   CLEAR_CYCLES  cycles chain_nreset is held low at load start (>=1)
//
// Ports
//   config_clock   in   clock for the controller and the chain
//   config_nreset  in   async active-low reset
//   start          in   begin a load (accepted in IDLE/DONE only)
//   abort          in   return to IDLE next cycle; has priority over start
//   word_data      in   host config word
//   word_valid     in   word_data valid
//   word_ready     out  controller accepts a word this cycle
//   chain_data     out  registered serial bit to the first tile config_in
//   chain_enable   out  registered shift enable to all tiles
//   chain_nreset   out  registered chain clear to all tiles
//   busy           out  load in progress
//   done           out  chain fully loaded (sticky until start/abort)
//   error          out  CRC mismatch (sticky until start/abort)
module config_chain_loader #(
   parameter int WORD_WIDTH   = 8,
   parameter int CHAIN_LENGTH = 96,
   parameter int CLEAR_CYCLES = 2
) (
   input  logic                  config_clock,
   input  logic                  config_nreset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  chain_data,
   output logic                  chain_enable,
   output logic                  chain_nreset,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
   localparam int WB_W  = $clog2(WORD_WIDTH);
   localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LENGTH - 1);
   localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_WIDTH - 1);
   localparam logic [CLR_W-1:0] LAST_CLR  = CLR_W'(CLEAR_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_SHIFT,
`ifdef CONFIG_CRC_EN
      S_CHECK,
`endif
      S_DONE
   } state_t;

   state_t                r_state, w_next;
   logic                  r_chain_data, r_chain_en, r_chain_nreset;
   logic [CNT_W-1:0]      r_cnt;
   logic [WB_W-1:0]       r_wbit;
   logic [CLR_W-1:0]      r_clr;
   // Holds the bits of the current word that still have to be shifted.
   // The MSB is always the next bit to drive. The bit on the chain now
   // lives in r_chain_data.
   logic [WORD_WIDTH-1:0] r_shreg;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_next = S_CLEAR;
         S_CLEAR:        if (r_clr == LAST_CLR) w_next = S_FETCH;
         S_FETCH:        if (word_valid) w_next = S_SHIFT;
         S_SHIFT: begin
            // The length check runs on every bit. The unused tail of a
            // partial last word is therefore dropped without being shifted.
            if (r_cnt == LAST_BIT)
`ifdef CONFIG_CRC_EN
               w_next = S_CHECK;
`else
               w_next = S_DONE;
`endif
            else if (r_wbit == LAST_WBIT)
               w_next = S_FETCH;
         end
`ifdef CONFIG_CRC_EN
         S_CHECK:        if (word_valid) w_next = S_DONE;
`endif
         default:        w_next = S_IDLE;
      endcase
      if (abort) w_next = S_IDLE;
   end

   always_ff @(posedge config_clock or negedge config_nreset) begin
      if (!config_nreset) begin
         r_state        <= S_IDLE;
         r_chain_data   <= 1'b0;
         r_chain_en     <= 1'b0;
         r_chain_nreset <= 1'b1;
         r_cnt          <= '0;
         r_wbit         <= '0;
         r_clr          <= '0;
         r_shreg        <= '0;
      end else begin
         r_state        <= w_next;
         // The chain outputs are loaded from the next state. This lets a
         // bit and its enable appear together in the cycle the controller
         // is in SHIFT, starting one cycle after the word is accepted.
         r_chain_en     <= (w_next == S_SHIFT);
         r_chain_nreset <= (w_next != S_CLEAR);
         r_chain_data   <= 1'b0;
         if (w_next == S_SHIFT)
            r_chain_data <= (r_state == S_FETCH) ? word_data[WORD_WIDTH-1]
                                                 : r_shreg[WORD_WIDTH-1];
         if (abort) begin
            r_cnt   <= '0;
            r_wbit  <= '0;
            r_clr   <= '0;
            r_shreg <= '0;
         end else begin
            case (r_state)
               S_IDLE, S_DONE: if (start) begin
                  r_cnt <= '0;
                  r_clr <= '0;
               end
               S_CLEAR: r_clr <= r_clr + CLR_W'(1);
               S_FETCH: if (word_valid) begin
                  r_shreg <= {word_data[WORD_WIDTH-2:0], 1'b0};
                  r_wbit  <= '0;
               end
               S_SHIFT: begin
                  r_shreg <= r_shreg << 1;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_wbit  <= r_wbit + WB_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

`ifdef CONFIG_CRC_EN
   logic [7:0] r_crc, w_crc_next, w_crc_word;
   logic       r_error;

   // MSB-first CRC-8 over the bit driven onto the chain in this cycle.
   assign w_crc_next = {r_crc[6:0], 1'b0} ^ ((r_crc[7] ^ r_chain_data) ? 8'h07 : 8'h00);
   assign w_crc_word = 8'(word_data);

   always_ff @(posedge config_clock or negedge config_nreset) begin
      if (!config_nreset) begin
         r_crc   <= '0;
         r_error <= 1'b0;
      end else if (abort) begin
         r_crc   <= '0;
         r_error <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: if (start) begin
               r_crc   <= '0;
               r_error <= 1'b0;
            end
            S_SHIFT: r_crc <= w_crc_next;
            S_CHECK: if (word_valid) r_error <= (w_crc_word != r_crc);
            default: ;
         endcase
      end
   end
   assign error = r_error;
`else
   assign error = 1'b0;
`endif

   always_comb begin
      word_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         S_CLEAR: busy = 1'b1;
         S_FETCH: begin
            busy       = 1'b1;
            word_ready = 1'b1;
         end
         S_SHIFT: busy = 1'b1;
`ifdef CONFIG_CRC_EN
         S_CHECK: begin
            busy       = 1'b1;
            word_ready = 1'b1;
         end
`endif
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign chain_data   = r_chain_data;
   assign chain_enable = r_chain_en;
   assign chain_nreset = r_chain_nreset;

endmodule
